tug_auto_player: RTL
====================

// Module: tug_auto_player
// PURPOSE
//   Automated opponent for the Tug-of-War game. Sits on the player side of the game's
//   interface: watches the 7-bit LED bar and drives one pushbutton line (wired to pbl or pbr in top).
//   Waits for a dark->lit round start, reacts after a level-dependent pseudo-random delay,
//   then holds the button for a fixed pulse. Never jumps the gun; stops playing once a win shows.
// PARAMETERS
//   HOLD_CYCLES  5      pb_out high time in clk cycles; >= the game's slow-enable period
//   LFSR_SEED    8'hA5  LFSR reset value; 8'h00 is replaced by 8'h01
// PORTS
//   clk         in   1  game clock (512 Hz); the only clock
//   rst         in   1  synchronous, active-high reset
//   en          in   1  1 = auto player active; 0 = pb_out forced low, FSM to IDLE
//   level       in   2  difficulty 0 (slow) .. 3 (fast)
//   leds_in     in   7  game leds_out, same clock domain, no synchroniser
//   pb_out      out  1  registered button press to the game
//   busy        out  1  high in REACT or PRESS
//   state_dbg   out  3  current FSM state encoding
// BEHAVIOUR
//   Reset: pb_out=0, busy=0, state=IDLE, lfsr=LFSR_SEED, counters=0.
//   LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1; advances every non-reset cycle; never 0.
//   Delay D = BASE[level] + lfsr[5:0]; BASE = {128,96,64,32} for level 0..3; D range 32..191, 8 bits.
//   Win patterns: WIN_L=7'b1110000, WIN_R=7'b0000111. Checked in every state except OVER.
//     A win has priority over all other transitions -> OVER, pb_out=0.
//   FSM (all transitions on the clk edge, pb_out/busy registered from next state):
//     IDLE : leds_in==0 -> DARK. Nonzero leds_in never starts a round from IDLE.
//     DARK : leds_in!=0 -> load cnt=D-1 from the current lfsr, -> REACT.
//     REACT: cnt!=0 -> cnt--. cnt==0 -> load hold=HOLD_CYCLES-1, -> PRESS.
//            leds_in==0 before expiry (opponent won the round) -> DARK, no press.
//     PRESS: pb_out=1; hold!=0 -> hold--; hold==0 -> IDLE.
//            Exactly HOLD_CYCLES high cycles, even if leds_in goes 0 meanwhile.
//     OVER : pb_out=0; leave only by rst.
//   Latency: leds_in first seen !=0 at edge k.
//     pb_out is high for the cycles after edges k+D .. k+D+HOLD_CYCLES-1.
//   A round gets at most one press. A new press needs a new 0 -> nonzero transition of leds_in.
//   en=0: in any state except OVER, next edge -> IDLE, pb_out=0; a press in progress is truncated.
//     en=0 in OVER -> stays in OVER.
//   level is sampled only at the DARK->REACT load. Changes during REACT do not affect the current round.
//   rst mid-round: all state cleared the same edge; pb_out low the following cycle.
// STRUCTURE
//   tug_pkg: state enum (IDLE, DARK, REACT, PRESS, OVER), WIN_L/WIN_R, BASE_DELAY table,
//     LED_W=7, DLY_W=8.
//   Sub-module lfsr8 (clk, rst, seed, q[7:0]): the pseudo-random source; FSM and counters stay here.
// TESTING
//   1 rst held 2 cycles with leds_in=0000100 -> pb_out=0, busy=0, state_dbg=IDLE.
//     No press for 500 cycles, since a dark phase was never seen.
//   2 level=3, seed 8'hA5, leds 0 then 0001000 -> one pulse, high exactly 5 cycles.
//     Pulse starts D=32+lfsr[5:0] edges after the lit edge (bench LFSR model). busy high throughout.
//   3 level=0, leds lit then back to 0 after 10 cycles -> no pulse, state_dbg=DARK.
//     Next lit round presses normally.
//   4 leds_in=1110000 mid-REACT -> OVER, pb_out=0.
//     Toggle leds 0/0001000 for 2000 cycles -> no press. rst -> IDLE.
//   5 en dropped on the 2nd PRESS cycle -> pb_out 0 next cycle, state IDLE.
//     en=1 and leds held lit -> no re-press until the next dark->lit transition.
//   6 4 back-to-back rounds at level 1 -> 4 pulses. Each delay is in 96..159.
//     Delays are not all equal. lfsr never 0 (assertion).

Source files
------------

// File: rtl/tug_pkg.sv
// Shared types and constants for the Tug-of-War automatic opponent.
// Holds the FSM state encoding, the win patterns and the reaction-delay table.
package tug_pkg;

    localparam int LED_W = 7;
    localparam int DLY_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DARK  = 3'd1,
        REACT = 3'd2,
        PRESS = 3'd3,
        OVER  = 3'd4
    } state_e;

    localparam logic [LED_W-1:0] WIN_L = 7'b1110000;
    localparam logic [LED_W-1:0] WIN_R = 7'b0000111;

    // Element [lvl] is the base reaction delay for difficulty lvl (0 = slowest).
    localparam logic [3:0][DLY_W-1:0] BASE_DELAY = {8'd32, 8'd64, 8'd96, 8'd128};

    function automatic logic [DLY_W-1:0] react_delay(input logic [1:0] lvl,
                                                      input logic [7:0] rnd);
        return BASE_DELAY[lvl] + {2'b00, rnd[5:0]};
    endfunction

endpackage

// File: rtl/tug_auto_player_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) advancing every non-reset cycle.
// An all-zero seed would lock the register, so it is replaced by 8'h01.
module lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic [7:0] seed_safe;

    assign seed_safe = (seed == 8'h00) ? 8'h01 : seed;

    assign lfsr_d[0] = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    for (genvar gi = 1; gi < 8; gi++) begin : g_shift
        assign lfsr_d[gi] = lfsr_q[gi-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= seed_safe;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/tug_auto_player.sv
// Automatic Tug-of-War opponent: waits for a dark->lit round start, reacts after a
// level-dependent pseudo-random delay, then holds its button for HOLD_CYCLES cycles.
module tug_auto_player
    import tug_pkg::*;
#(
    parameter int         HOLD_CYCLES = 5,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       level,
    input  logic [LED_W-1:0] leds_in,
    output logic             pb_out,
    output logic             busy,
    output logic [2:0]       state_dbg
);

    localparam logic [DLY_W-1:0] HOLD_LOAD = DLY_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [DLY_W-1:0] hold_q, hold_d;
    logic             pb_q, pb_d;
    logic             busy_q, busy_d;
    logic [7:0]       lfsr_q;
    logic             win;
    logic             dark;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

    assign win  = (leds_in == WIN_L) || (leds_in == WIN_R);
    assign dark = (leds_in == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            pb_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            pb_q    <= pb_d;
            busy_q  <= busy_d;
        end
    end

    // A visible win freezes the player; en=0 aborts anything short of that.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        if (state_q != OVER && win) begin
            state_d = OVER;
        end else if (!en && state_q != OVER) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dark) state_d = DARK;
                end
                DARK: begin
                    if (!dark) begin
                        cnt_d   = react_delay(level, lfsr_q) - 8'd1;
                        state_d = REACT;
                    end
                end
                REACT: begin
                    // Bar going dark means the round ended before we reacted.
                    if (dark) begin
                        state_d = DARK;
                    end else if (cnt_q == '0) begin
                        hold_d  = HOLD_LOAD;
                        state_d = PRESS;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                PRESS: begin
                    if (hold_q == '0) state_d = IDLE;
                    else              hold_d  = hold_q - 8'd1;
                end
                OVER: begin
                    state_d = OVER;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        pb_d   = (state_d == PRESS);
        busy_d = (state_d == REACT) || (state_d == PRESS);
    end

    assign pb_out    = pb_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule
